// File: rtl/pcss_pkg.sv
// Shared sizing helpers and debug field constants for the chip transmit scheduler.
package pcss_pkg;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = (int'(32'd1 << i) < v) ? (i + 1) : r;
    end
    return r;
  endfunction

  function automatic int tag_width(input int n);
    return (log2c(n) < 1) ? 1 : log2c(n);
  endfunction

  localparam int FW_DEF      = 59;
  localparam int B_DEF       = 4;
  localparam int CONNECT_DEF = 2;

  // data_out layout: {tag[ATW-1:0], flit[FTW-1:0]}
  localparam int FTW = FW_DEF;
  localparam int ATW = tag_width(CONNECT_DEF);

endpackage

// File: rtl/chip_tx_fifo.sv
// Depth-B synchronous FIFO with combinational head, full/empty and a sticky overflow flag.
module chip_tx_fifo
  import pcss_pkg::*;
#(
  parameter int FW = 59,
  parameter int B  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [FW-1:0] wr_data,
  input  logic          rd_en,
  output logic [FW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  localparam int CW = log2c(B) + 1;
  localparam int IW = (log2c(B) < 1) ? 1 : log2c(B);
  localparam logic [CW-1:0] CNT_FULL = CW'(B);
  localparam logic [IW-1:0] IDX_LAST = IW'(B - 1);

  logic [FW-1:0] mem_q [B];
  logic [FW-1:0] mem_d [B];
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push_s, pop_s;

  assign full     = (cnt_q == CNT_FULL);
  assign empty    = (cnt_q == {CW{1'b0}});
  assign pop_s    = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write to a full buffer is still accepted.
  assign push_s   = wr_en && (!full || pop_s);
  assign rd_data  = mem_q[rd_idx_q];
  assign overflow = ovf_q;

  always_comb begin
    mem_d    = mem_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push_s) begin
      mem_d[wr_idx_q] = wr_data;
      wr_idx_d = (wr_idx_q == IDX_LAST) ? {IW{1'b0}} : (wr_idx_q + IW'(1));
    end else begin
      ovf_d = ovf_q | wr_en;
    end
    if (pop_s) begin
      rd_idx_d = (rd_idx_q == IDX_LAST) ? {IW{1'b0}} : (rd_idx_q + IW'(1));
    end else begin
      rd_idx_d = rd_idx_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx_q <= {IW{1'b0}};
      rd_idx_q <= {IW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is qualified by the counters, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/chip_tx_scheduler.sv
// Round-robin scheduler sharing one chip_interface transmit path among CONNECT NoC channels.
module chip_tx_scheduler
  import pcss_pkg::*;
#(
  parameter int FW      = 59,
  parameter int B       = 4,
  parameter int CONNECT = 2,
  localparam int TW     = tag_width(CONNECT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FW*CONNECT-1:0] flit_in_noc,
  input  logic [CONNECT-1:0]    flit_in_wr_noc,
  output logic [CONNECT-1:0]    credit_out_noc,
  input  logic                  send_fifo_full,
  input  logic [CONNECT-1:0]    connect_available,
  output logic [FW+TW-1:0]      data_out,
  output logic                  data_out_wr,
  output logic                  overflow_err
);

  localparam logic [TW-1:0] PTR_LAST = TW'(CONNECT - 1);

  logic [FW-1:0]      head_s [CONNECT];
  logic [CONNECT-1:0] full_s, empty_s, ovf_s, pop_s, elig_s;
  logic               unused_full_s;

  logic               grant_vld_s, hit_s;
  logic [TW-1:0]      grant_idx_s, cand_s;

  logic [TW-1:0]      ptr_q, ptr_d;
  logic [FW+TW-1:0]   data_out_q, data_out_d;
  logic               data_out_wr_q, data_out_wr_d;
  logic [CONNECT-1:0] credit_q, credit_d;

  for (genvar j = 0; j < CONNECT; j++) begin : g_fifo
    chip_tx_fifo #(.FW(FW), .B(B)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (flit_in_wr_noc[j]),
      .wr_data  (flit_in_noc[FW*j +: FW]),
      .rd_en    (pop_s[j]),
      .rd_data  (head_s[j]),
      .full     (full_s[j]),
      .empty    (empty_s[j]),
      .overflow (ovf_s[j])
    );
  end

  assign unused_full_s = ^full_s;
  assign elig_s = ~empty_s & connect_available & {CONNECT{~send_fifo_full}};

  // First eligible channel scanning upward from the pointer, wrapping.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {TW{1'b0}};
    cand_s      = {TW{1'b0}};
    hit_s       = 1'b0;
    for (int k = 0; k < CONNECT; k++) begin
      cand_s      = TW'((int'(ptr_q) + k) % CONNECT);
      hit_s       = !grant_vld_s && elig_s[cand_s];
      grant_idx_s = hit_s ? cand_s : grant_idx_s;
      grant_vld_s = grant_vld_s | hit_s;
    end
  end

  always_comb begin
    pop_s         = grant_vld_s ? (CONNECT'(1) << grant_idx_s) : {CONNECT{1'b0}};
    ptr_d         = ptr_q;
    data_out_d    = data_out_q;
    data_out_wr_d = grant_vld_s;
    credit_d      = pop_s;
    if (grant_vld_s) begin
      ptr_d      = (grant_idx_s == PTR_LAST) ? {TW{1'b0}} : (grant_idx_s + TW'(1));
      data_out_d = {grant_idx_s, head_s[grant_idx_s]};
    end else begin
      ptr_d      = ptr_q;
      data_out_d = data_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= {TW{1'b0}};
      data_out_q    <= {(FW+TW){1'b0}};
      data_out_wr_q <= 1'b0;
      credit_q      <= {CONNECT{1'b0}};
    end else begin
      ptr_q         <= ptr_d;
      data_out_q    <= data_out_d;
      data_out_wr_q <= data_out_wr_d;
      credit_q      <= credit_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_wr    = data_out_wr_q;
  assign credit_out_noc = credit_q;
  assign overflow_err   = |ovf_s;

endmodule

// File: tb/tb_chip_tx_scheduler.sv
// Self-checking bench: queue-based reference model plus directed scenarios and random traffic.
module tb_chip_tx_scheduler;

  localparam int FW = 59;
  localparam int B  = 4;
  localparam int C  = 2;
  localparam int TW = 1;
  localparam int DW = FW + TW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [FW*C-1:0] flit_in_noc;
  logic [C-1:0]    flit_in_wr_noc;
  logic [C-1:0]    credit_out_noc;
  logic            send_fifo_full;
  logic [C-1:0]    connect_available;
  logic [DW-1:0]   data_out;
  logic            data_out_wr;
  logic            overflow_err;

  always #5 clk = ~clk;

  chip_tx_scheduler #(.FW(FW), .B(B), .CONNECT(C)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flit_in_noc       (flit_in_noc),
    .flit_in_wr_noc    (flit_in_wr_noc),
    .credit_out_noc    (credit_out_noc),
    .send_fifo_full    (send_fifo_full),
    .connect_available (connect_available),
    .data_out          (data_out),
    .data_out_wr       (data_out_wr),
    .overflow_err      (overflow_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel queues, a pointer integer and the expected output registers.
  logic [FW-1:0] mq [C][$];
  int            mptr;
  logic [DW-1:0] e_do;
  logic          e_wr;
  logic [C-1:0]  e_cr;
  logic          e_ovf;
  bit            model_live = 1'b0;

  task automatic model_step();
    int g;
    int c;
    logic [FW-1:0] f;
    logic [TW-1:0] gt;
    model_live = 1'b1;
    if (!rst_n) begin
      for (int j = 0; j < C; j++) mq[j].delete();
      mptr  = 0;
      e_do  = '0;
      e_wr  = 1'b0;
      e_cr  = '0;
      e_ovf = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < C; k++) begin
        c = (mptr + k) % C;
        if (g < 0 && !send_fifo_full && connect_available[c] && mq[c].size() > 0) g = c;
      end
      e_wr = 1'b0;
      e_cr = '0;
      if (g >= 0) begin
        f       = mq[g].pop_front();
        gt      = g[TW-1:0];
        e_do    = {gt, f};
        e_wr    = 1'b1;
        e_cr[g] = 1'b1;
        mptr    = (g + 1) % C;
      end
      for (int j = 0; j < C; j++) begin
        if (flit_in_wr_noc[j]) begin
          if (mq[j].size() < B) mq[j].push_back(flit_in_noc[FW*j +: FW]);
          else e_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Every-cycle comparison against the model, plus a log of emitted words for directed checks.
  logic [DW-1:0] dlog [$];
  int            ccnt [C];

  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("data_out_wr", {63'd0, data_out_wr}, {63'd0, e_wr});
        chk("credit_out_noc", {62'd0, credit_out_noc}, {62'd0, e_cr});
        chk("overflow_err", {63'd0, overflow_err}, {63'd0, e_ovf});
        chk("data_out", {4'd0, data_out}, {4'd0, e_do});
        if (data_out_wr === 1'b1) dlog.push_back(data_out);
        for (int j = 0; j < C; j++) if (credit_out_noc[j] === 1'b1) ccnt[j]++;
      end
    end
  end

  task automatic clear_log();
    dlog.delete();
    for (int j = 0; j < C; j++) ccnt[j] = 0;
  endtask

  task automatic put(input int ch, input logic [FW-1:0] v);
    flit_in_wr_noc[ch]         = 1'b1;
    flit_in_noc[FW*ch +: FW]   = v;
  endtask

  initial begin
    logic [FW-1:0] rv;
    rst_n             = 1'b0;
    flit_in_noc       = '0;
    flit_in_wr_noc    = '0;
    send_fifo_full    = 1'b0;
    connect_available = '0;
    clear_log();
    ticks(3);
    rst_n = 1'b1;

    // 1: three flits on channel 0
    connect_available = 2'b11;
    clear_log();
    put(0, 59'h111); tick();
    put(0, 59'h222); tick();
    put(0, 59'h333); tick();
    flit_in_wr_noc = '0;
    ticks(4);
    chk("t1_count", 64'(dlog.size()), 64'd3);
    if (dlog.size() == 3) begin
      chk("t1_w0", {4'd0, dlog[0]}, {4'd0, 1'b0, 59'h111});
      chk("t1_w1", {4'd0, dlog[1]}, {4'd0, 1'b0, 59'h222});
      chk("t1_w2", {4'd0, dlog[2]}, {4'd0, 1'b0, 59'h333});
    end
    chk("t1_cred0", 64'(ccnt[0]), 64'd3);

    // 2: both buffers preloaded, pointer sits at 1 after test 1
    connect_available = 2'b00;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      put(0, 59'hA0 + 59'(i));
      put(1, 59'hB0 + 59'(i));
      tick();
    end
    flit_in_wr_noc    = '0;
    connect_available = 2'b11;
    ticks(10);
    chk("t2_count", 64'(dlog.size()), 64'd8);
    for (int i = 0; i < 8 && i < dlog.size(); i++) begin
      chk("t2_tag", {63'd0, dlog[i][FW]}, 64'((i + 1) % 2));
      chk("t2_payload", {5'd0, dlog[i][FW-1:0]},
          ((i + 1) % 2 == 1) ? 64'(59'hB0 + 59'(i / 2)) : 64'(59'hA0 + 59'(i / 2)));
    end
    chk("t2_cred0", 64'(ccnt[0]), 64'd4);
    chk("t2_cred1", 64'(ccnt[1]), 64'd4);

    // 3: send_fifo_full stalls both channels
    clear_log();
    send_fifo_full = 1'b1;
    put(0, 59'hC0);
    put(1, 59'hC1);
    tick();
    flit_in_wr_noc = '0;
    ticks(5);
    chk("t3_stalled", 64'(dlog.size()), 64'd0);
    send_fifo_full = 1'b0;
    ticks(4);
    chk("t3_count", 64'(dlog.size()), 64'd2);
    if (dlog.size() > 0) chk("t3_first_tag", {63'd0, dlog[0][FW]}, 64'd1);

    // 4: only channel 1 available
    clear_log();
    connect_available = 2'b10;
    put(0, 59'hD0); put(1, 59'hE0); tick();
    put(0, 59'hD1); put(1, 59'hE1); tick();
    flit_in_wr_noc = '0;
    ticks(3);
    chk("t4_only1_count", 64'(dlog.size()), 64'd2);
    for (int i = 0; i < dlog.size(); i++) chk("t4_only1_tag", {63'd0, dlog[i][FW]}, 64'd1);
    connect_available = 2'b11;
    ticks(4);
    chk("t4_total", 64'(dlog.size()), 64'd4);
    if (dlog.size() == 4) chk("t4_ch0", {4'd0, dlog[2]}, {4'd0, 1'b0, 59'hD0});

    // 5: overflow on channel 1
    clear_log();
    connect_available = 2'b00;
    for (int i = 0; i < 5; i++) begin
      put(1, 59'hF0 + 59'(i));
      tick();
    end
    flit_in_wr_noc = '0;
    tick();
    chk("t5_ovf_set", {63'd0, overflow_err}, 64'd1);
    connect_available = 2'b11;
    ticks(8);
    chk("t5_count", 64'(dlog.size()), 64'd4);
    chk("t5_cred1", 64'(ccnt[1]), 64'd4);
    chk("t5_ovf_sticky", {63'd0, overflow_err}, 64'd1);
    if (dlog.size() == 4) chk("t5_last", {4'd0, dlog[3]}, {4'd0, 1'b1, 59'hF3});

    // 6: reset while flits are buffered
    connect_available = 2'b00;
    for (int i = 0; i < 3; i++) begin
      put(0, 59'h70 + 59'(i));
      tick();
    end
    flit_in_wr_noc = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_log();
    chk("t6_ovf_clr", {63'd0, overflow_err}, 64'd0);
    connect_available = 2'b11;
    ticks(5);
    chk("t6_empty", 64'(dlog.size()), 64'd0);
    put(0, 59'h81); put(1, 59'h82); tick();
    flit_in_wr_noc = '0;
    ticks(3);
    chk("t6_count", 64'(dlog.size()), 64'd2);
    if (dlog.size() > 0) chk("t6_ptr0", {63'd0, dlog[0][FW]}, 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < C; j++) begin
        rv = {$urandom, $urandom};
        flit_in_noc[FW*j +: FW] = rv;
        flit_in_wr_noc[j]       = ($urandom_range(0, 2) == 0);
        connect_available[j]    = ($urandom_range(0, 3) != 0);
      end
      send_fifo_full = ($urandom_range(0, 4) == 0);
      rst_n          = ($urandom_range(0, 299) != 0);
      tick();
    end
    flit_in_wr_noc = '0;
    rst_n          = 1'b1;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
